// File: rtl/cdb_arb_pkg.sv
// Shared types and helpers for the result-bus arbiter.
package cdb_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  // Index of the first set bit at or after start, wrapping modulo NUM_REQ.
  function automatic logic [SEL_W-1:0] first_set_rot(
    input logic [NUM_REQ-1:0] vec,
    input logic [SEL_W-1:0]   start
  );
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] res;
    res = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (vec[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_4x1.sv
// Four-input payload multiplexer.
module mux_4x1 #(
  parameter int dataWidth = 32
) (
  input  logic [dataWidth-1:0] in0,
  input  logic [dataWidth-1:0] in1,
  input  logic [dataWidth-1:0] in2,
  input  logic [dataWidth-1:0] in3,
  input  logic [1:0]           s,
  output logic [dataWidth-1:0] out
);

  always_comb begin
    out = in0;
    unique case (s)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/cdb_arbiter_4.sv
// Four-requester result-bus arbiter with a registered valid/ready output.
// Define CDB_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module cdb_arbiter_4
  import cdb_arb_pkg::*;
#(
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [dataWidth-1:0] in0,
  input  logic [dataWidth-1:0] in1,
  input  logic [dataWidth-1:0] in2,
  input  logic [dataWidth-1:0] in3,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 out_valid,
  output logic [dataWidth-1:0] out_data,
  output logic [SEL_W-1:0]     out_src,
  input  logic                 out_ready
);

  state_e               state_q, state_d;
  logic [dataWidth-1:0] data_q, data_d;
  logic [SEL_W-1:0]     src_q, src_d;
  logic [SEL_W-1:0]     start;
  logic [SEL_W-1:0]     win;
  logic [dataWidth-1:0] mux_out;
  logic                 slot_free;
  logic                 take;

`ifdef CDB_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [SEL_W-1:0] ptr_q, ptr_d;

  assign start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (take) ptr_d = win + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign win = first_set_rot(req, start);

  mux_4x1 #(
    .dataWidth(dataWidth)
  ) u_mux (
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .s  (win),
    .out(mux_out)
  );

  // Draining and refilling the slot in one cycle keeps full throughput.
  assign slot_free = (state_q == ST_EMPTY) || out_ready;
  assign take      = !rst && slot_free && (|req);
  assign grant     = take ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    if (take) begin
      data_d = mux_out;
      src_d  = win;
    end
    unique case (state_q)
      ST_EMPTY: if (take) state_d = ST_FULL;
      ST_FULL:  if (out_ready) state_d = take ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter_4.sv
// Scoreboard bench for cdb_arbiter_4 (round-robin or fixed-priority build).
module tb_cdb_arbiter_4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] in0, in1, in2, in3;
  logic [3:0]  grant;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int checks;
  int errors;

  logic [33:0] sb_q[$];
  logic        mdl_valid;
  logic [1:0]  mdl_ptr;

  cdb_arbiter_4 #(
    .dataWidth(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .grant    (grant),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] in_of(input logic [1:0] i);
    case (i)
      2'd0: return in0;
      2'd1: return in1;
      2'd2: return in2;
      default: return in3;
    endcase
  endfunction

  task automatic set_in(input logic [1:0] i, input logic [31:0] v);
    case (i)
      2'd0: in0 = v;
      2'd1: in1 = v;
      2'd2: in2 = v;
      default: in3 = v;
    endcase
  endtask

  // One clock: drive, check grant/output vs model, clock, update model.
  task automatic cycle(input logic [3:0] r, input logic rdy, input logic rs);
    logic [3:0]  eg;
    logic [1:0]  w;
    logic        found;
    logic        free;
    logic [33:0] e;
    req = r;
    out_ready = rdy;
    rst = rs;
    #1;
    eg = '0;
    w = '0;
    found = 1'b0;
    free = !mdl_valid || rdy;
    if (!rs && free) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && r[2'(int'(mdl_ptr) + k)]) begin
          found = 1'b1;
          w = 2'(int'(mdl_ptr) + k);
        end
      end
    end
    if (found) eg = 4'b0001 << w;
    chk("grant", 64'(grant), 64'(eg));
    chk("out_valid", 64'(out_valid), 64'(mdl_valid));
    if (!rs && mdl_valid && rdy) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("beat_data", 64'(out_data), 64'(e[33:2]));
        chk("beat_src", 64'(out_src), 64'(e[1:0]));
      end
    end
    if (found) sb_q.push_back({in_of(w), w});
    @(posedge clk);
    #1;
    if (rs) begin
      mdl_valid = 1'b0;
      mdl_ptr = '0;
      sb_q.delete();
    end else if (found) begin
      mdl_valid = 1'b1;
`ifndef CDB_ARB_FIXED_PRIO_EN
      mdl_ptr = w + 2'd1;
`endif
      set_in(w, $urandom);
    end else if (free) begin
      mdl_valid = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mdl_valid = 1'b0;
    mdl_ptr = '0;
    req = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    in0 = 32'h1000_0000;
    in1 = 32'h1111_1111;
    in2 = 32'h2222_2222;
    in3 = 32'h3333_3333;

    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    req = '0;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);

    in2 = 32'hDEAD_BEEF;
    cycle(4'b0100, 1'b1, 1'b0);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_data", 64'(out_data), 64'hDEAD_BEEF);
    chk("first_src", 64'(out_src), 64'd2);
    cycle(4'b0000, 1'b1, 1'b0);

    cycle(4'b1001, 1'b1, 1'b0);
    cycle(4'b1001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);

    cycle(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);

    cycle(4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0011, 1'b0, 1'b0);
      if (sb_q.size() != 0)
        chk("stall_hold", 64'(out_data), 64'(sb_q[0][33:2]));
    end
    cycle(4'b0011, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);

    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++)
      cycle(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);

    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
